// File: rtl/byte_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer_pkg
// Description : Shared constants, types and helpers for byte_packer_64.
//               DATA_W_DEF / IN_W_DEF : default word and beat widths
//               num_lanes()           : number of input lanes per word
//               lane_idx_t            : lane counter type for the defaults
//               word_t                : 64-bit output word type
// Revision    : 1.0 - initial release
// ============================================================================
package byte_packer_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int IN_W_DEF   = 8;

    function automatic int num_lanes(input int data_w, input int in_w);
        return data_w / in_w;
    endfunction

    typedef logic [$clog2(num_lanes(DATA_W_DEF, IN_W_DEF))-1:0] lane_idx_t;
    typedef logic [63:0] word_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer_64.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer_64
// Description : Packs narrow input beats into one DATA_W-bit word presented on
//               a valid/ready output. in_last closes a word early; unwritten
//               lanes are zero and out_bytes reports the lane count.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-high reset
//               in_valid   - input beat present
//               in_data    - input beat (IN_W bits)
//               in_last    - beat closes the current word
//               in_ready   - beat can be accepted this cycle
//               out_valid  - out_data holds a completed word
//               out_data   - assembled word (DATA_W bits)
//               out_bytes  - number of valid lanes in out_data
//               out_ready  - downstream accepts the word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer_64
    import byte_packer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IN_W      = IN_W_DEF,
    parameter int LSB_FIRST = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [IN_W-1:0]                           in_data,
    input  logic                                      in_last,
    output logic                                      in_ready,
    output logic                                      out_valid,
    output logic [DATA_W-1:0]                         out_data,
    output logic [$clog2(num_lanes(DATA_W, IN_W)):0]  out_bytes,
    input  logic                                      out_ready
);

    localparam int c_num_lanes = num_lanes(DATA_W, IN_W);
    localparam int c_lane_w    = (c_num_lanes > 1) ? $clog2(c_num_lanes) : 1;
    localparam int c_bytes_w   = $clog2(c_num_lanes) + 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_num_lanes - 1);

    logic [DATA_W-1:0]    r_asm;
    logic [c_lane_w-1:0]  r_lane;
    logic [DATA_W-1:0]    r_out_data;
    logic [c_bytes_w-1:0] r_out_bytes;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_complete;
    logic                 w_retire;
    logic [c_lane_w-1:0]  w_slot;
    logic [DATA_W-1:0]    w_merged;

    // Input only stalls while a finished word is waiting to be taken.
    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && ((r_lane == c_last_lane) || in_last);
    assign w_retire   = r_out_valid && out_ready;

    // Physical lane for the current beat; MSB-first mode mirrors the index.
    assign w_slot = (LSB_FIRST != 0) ? r_lane : (c_last_lane - r_lane);

    // r_asm is cleared whenever a word starts, so lanes not yet written are
    // already zero and the merge only has to drop the new beat in place.
    always_comb begin
        w_merged = r_asm;
        for (int i = 0; i < c_num_lanes; i++) begin
            if (w_slot == c_lane_w'(i)) begin
                w_merged[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_asm       <= '0;
            r_lane      <= '0;
            r_out_data  <= '0;
            r_out_bytes <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_out_data  <= w_merged;
                    r_out_bytes <= c_bytes_w'(r_lane) + c_bytes_w'(1);
                    r_asm       <= '0;
                    r_lane      <= '0;
                end else begin
                    r_asm       <= w_merged;
                    r_lane      <= r_lane + c_lane_w'(1);
                end
            end
            // A completing beat in the retire cycle keeps valid high, which
            // gives back-to-back words without a bubble.
            if (w_complete) begin
                r_out_valid <= 1'b1;
            end else if (w_retire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_bytes = r_out_bytes;

endmodule
`default_nettype wire

// File: tb/tb_byte_packer_64.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_packer_64
// Description : Self-checking bench for byte_packer_64. Two instances share
//               the stimulus: one LSB-first, one MSB-first. Directed scenarios
//               are followed by a randomized run compared against a
//               beat-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_packer_64;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [63:0] out_data_a;
    logic [3:0]  out_bytes_a;
    logic        in_ready_b, out_valid_b;
    logic [63:0] out_data_b;
    logic [3:0]  out_bytes_b;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 0;

    logic [7:0]  m_beats[$];
    logic [67:0] exp_a[$], exp_b[$];
    logic [67:0] obs_a[$], obs_b[$];

    byte_packer_64 #(.DATA_W(64), .IN_W(8), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_a), .out_valid(out_valid_a),
        .out_data(out_data_a), .out_bytes(out_bytes_a), .out_ready(out_ready)
    );

    byte_packer_64 #(.DATA_W(64), .IN_W(8), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_bytes(out_bytes_b), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word that retires (sampled mid-cycle, retires at next edge).
    always @(negedge clk) begin
        if (!reset && out_valid_a && out_ready) obs_a.push_back({out_bytes_a, out_data_a});
        if (!reset && out_valid_b && out_ready) obs_b.push_back({out_bytes_b, out_data_b});
    end

    // Reference model: collect beats; a word is the beat list laid into lanes.
    task automatic model_accept(input logic [7:0] d, input logic last);
        logic [63:0] wa, wb;
        int n;
        m_beats.push_back(d);
        if (last || m_beats.size() == 8) begin
            wa = '0;
            wb = '0;
            n  = m_beats.size();
            for (int k = 0; k < n; k++) begin
                wa = wa | (64'(m_beats[k]) << (8 * k));
                wb = wb | (64'(m_beats[k]) << (8 * (7 - k)));
            end
            exp_a.push_back({4'(n), wa});
            exp_b.push_back({4'(n), wb});
            m_beats.delete();
        end
    endtask

    // Present one beat and hold it until accepted; returns at edge+1.
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 200; t++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (acc) begin
            model_accept(d, last);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %h not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
        checks++; if (out_data_a !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data_a); end
        checks++; if (out_bytes_a !== 4'd0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", out_bytes_a); end
        checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready_a, in_ready_b); end
        reset = 1'b0;
        idle();
        @(posedge clk); #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_no_accept: valid got %b want 0", out_valid_a); end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        idle();
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", out_valid_a); end
        checks++; if (out_data_a !== 64'h0807060504030201) begin errors++; $display("FAIL full_data: got %h want 0807060504030201", out_data_a); end
        checks++; if (out_bytes_a !== 4'd8) begin errors++; $display("FAIL full_bytes: got %0d want 8", out_bytes_a); end
        checks++; if (out_data_b !== 64'h0102030405060708) begin errors++; $display("FAIL full_msb_data: got %h want 0102030405060708", out_data_b); end
        @(posedge clk); #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL full_one_cycle: valid got %b want 0", out_valid_a); end
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b1);
        idle();
        checks++; if (out_data_a !== 64'h0000000000CCBBAA) begin errors++; $display("FAIL partial_data: got %h want 0000000000ccbbaa", out_data_a); end
        checks++; if (out_bytes_a !== 4'd3 || out_bytes_b !== 4'd3) begin errors++; $display("FAIL partial_bytes: got %0d/%0d want 3/3", out_bytes_a, out_bytes_b); end
        checks++; if (out_data_b !== 64'hAABBCC0000000000) begin errors++; $display("FAIL partial_msb_data: got %h want aabbcc0000000000", out_data_b); end
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        idle();
        checks++; if (out_data_a !== 64'h0807060504030201 || out_bytes_a !== 4'd8) begin errors++; $display("FAIL partial_residue: got %h/%0d want 0807060504030201/8", out_data_a, out_bytes_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'h11 + 8'(i), 1'b0);
        idle();
        for (int c = 0; c < 5; c++) begin
            checks++; if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b/%b want 0/0", c, in_ready_a, in_ready_b); end
            checks++; if (out_valid_a !== 1'b1 || out_data_a !== 64'h1817161514131211 || out_bytes_a !== 4'd8) begin errors++; $display("FAIL bp_stable: cycle %0d got %b %h %0d want 1 1817161514131211 8", c, out_valid_a, out_data_a, out_bytes_a); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL bp_retire: valid/in_ready got %b/%b want 0/1", out_valid_a, in_ready_a); end
        checks++; if (out_data_a !== 64'h1817161514131211 || out_bytes_a !== 4'd8) begin errors++; $display("FAIL bp_hold: got %h/%0d want 1817161514131211/8", out_data_a, out_bytes_a); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_beat(8'hDE, 1'b0);
        send_beat(8'hAD, 1'b0);
        send_beat(8'hBE, 1'b0);
        send_beat(8'hEF, 1'b0);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_beats.delete();
        checks++; if (out_valid_a !== 1'b0 || out_data_a !== 64'h0) begin errors++; $display("FAIL mid_reset_clear: got %b/%h want 0/0", out_valid_a, out_data_a); end
        for (int i = 0; i < 8; i++) send_beat(8'h21 + 8'(i), 1'b0);
        idle();
        checks++; if (out_data_a !== 64'h2827262524232221) begin errors++; $display("FAIL mid_reset_data: got %h want 2827262524232221", out_data_a); end
        checks++; if (out_data_b !== 64'h2122232425262728) begin errors++; $display("FAIL mid_reset_msb_data: got %h want 2122232425262728", out_data_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 64'h0102030405060708) begin errors++; $display("FAIL b2b_first: got %b %h want 1 0102030405060708", out_valid_b, out_data_b); end
        send_beat(8'h77, 1'b1);
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 64'h7700000000000000 || out_bytes_b !== 4'd1) begin errors++; $display("FAIL b2b_second: got %b %h %0d want 1 7700000000000000 1", out_valid_b, out_data_b, out_bytes_b); end
        send_beat(8'h78, 1'b1);
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 64'h0000000000000078 || out_bytes_a !== 4'd1) begin errors++; $display("FAIL b2b_third: got %b %h %0d want 1 0000000000000078 1", out_valid_a, out_data_a, out_bytes_a); end
        idle();
        @(posedge clk); #1;
        checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL b2b_drop: valid got %b want 0", out_valid_b); end
    endtask

    task automatic test_random();
        int base_a, base_b, n;
        bit drained;
        exp_a.delete();
        exp_b.delete();
        m_beats.delete();
        base_a = obs_a.size();
        base_b = obs_b.size();
        rand_bp = 1;
        for (int w = 0; w < 40; w++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                send_beat(8'($urandom), (k == n - 1) && ((n < 8) || ($urandom_range(0, 1) == 1)));
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                    out_ready = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                end
            end
        end
        idle();
        rand_bp = 0;
        out_ready = 1'b1;
        drained = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (obs_a.size() - base_a == exp_a.size() && obs_b.size() - base_b == exp_b.size()) begin
                drained = 1;
                break;
            end
        end
        checks++; if (!drained) begin errors++; $display("FAIL rand_count: got %0d/%0d words want %0d/%0d", obs_a.size() - base_a, obs_b.size() - base_b, exp_a.size(), exp_b.size()); end
        for (int i = 0; i < exp_a.size() && base_a + i < obs_a.size(); i++) begin
            checks++; if (obs_a[base_a + i] !== exp_a[i]) begin errors++; $display("FAIL rand_lsb_word%0d: got %h want %h", i, obs_a[base_a + i], exp_a[i]); end
        end
        for (int i = 0; i < exp_b.size() && base_b + i < obs_b.size(); i++) begin
            checks++; if (obs_b[base_b + i] !== exp_b[i]) begin errors++; $display("FAIL rand_msb_word%0d: got %h want %h", i, obs_b[base_b + i], exp_b[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_packer_64.md
Name: byte_packer_64

Overview:
Upstream feeder for the 64-bit data register. Assembles a stream of narrow input beats (bytes by default) into one DATA_W-bit word and presents it on a valid/ready output, whose out_data drives the register's data_in. Supports early word termination (in_last) so that partial words are zero-padded and flagged with a byte count.

Parameters:
DATA_W, 64, output word width; must be an integer multiple of IN_W
IN_W, 8, input beat width
LSB_FIRST, 1, 1: first beat lands in bits [IN_W-1:0]; 0: first beat lands in the top lane

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat present
in_data  input  IN_W  input beat
in_last  input  1  beat is the final lane of the current word; qualified by in_valid
in_ready  output  1  block can accept a beat this cycle
out_valid  output  1  out_data holds a completed word
out_data  output  DATA_W  assembled word; feeds the 64-bit register's data_in
out_bytes  output  $clog2(NUM_LANES)+1  number of valid lanes in out_data (1..NUM_LANES)
out_ready  input  1  downstream accepts the word this cycle

Behaviour:
- NUM_LANES = DATA_W/IN_W. With the defaults this is 8.
- Reset: reset=1 sampled at a clk edge clears the following: out_valid=0, out_data=0, out_bytes=0, lane counter=0, assembly register=0.
  - A partially assembled word is discarded.
  - Reset has priority over every other event in the same cycle.
- Internal state:
  - assembly register asm (DATA_W wide).
  - lane counter lane (0..NUM_LANES-1).
  - output register (out_data, out_bytes, out_valid).
- in_ready = !(out_valid && !out_ready). The input stalls only while a finished word is waiting.
- Input handshake:
  - A beat is accepted when in_valid && in_ready.
  - When in_valid=1 and in_ready=0, the beat is ignored; upstream must hold it stable.
- Lane placement:
  - Accepted beat at lane k writes bits [k*IN_W +: IN_W] when LSB_FIRST=1.
  - It writes [(NUM_LANES-1-k)*IN_W +: IN_W] when LSB_FIRST=0.
- Non-completing beat (lane < NUM_LANES-1 and in_last=0): lane increments and asm is updated. The output register is unaffected except for the retire rule below.
- Completing beat (lane == NUM_LANES-1, or in_last=1):
  - At the same edge, out_data is loaded with asm merged with the new beat. Lanes not yet written are forced to 0.
  - out_bytes = lane+1 and out_valid=1.
  - lane and asm are cleared to 0.
- Latency: the word is visible on out_data/out_valid in the cycle after the clk edge that accepted its completing beat.
- Output handshake:
  - The word retires when out_valid && out_ready.
  - On retire with no completing beat in the same cycle: out_valid->0. out_data and out_bytes hold their last values.
  - Retire and completing beat in the same cycle: the new word is loaded and out_valid stays 1. This gives back-to-back words with no bubble.
- Stability: while out_valid=1 and out_ready=0, out_data and out_bytes must not change.
- in_last on lane 0 produces a 1-lane word (out_bytes=1).
- in_last on lane NUM_LANES-1 is identical to a normal full word.
- Sustained throughput: one word per NUM_LANES accepted beats.

Decomposition:
- Package byte_packer_pkg holds:
  - constants DATA_W_DEF=64, IN_W_DEF=8.
  - function num_lanes(DATA_W, IN_W).
  - typedef lane_idx_t for the lane counter.
  - typedef word_t logic[63:0].
- No sub-module: a single module containing the counter, assembly register and output register.

Test Plan:
1. Reset held 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_bytes=0, in_ready=1; no beat accepted.
2. LSB_FIRST=1, out_ready=1, beats 0x01..0x08 back-to-back -> one cycle after 8th beat: out_data=64'h0807060504030201, out_bytes=8, out_valid high exactly 1 cycle.
3. Beats 0xAA, 0xBB, 0xCC with in_last on 0xCC -> out_data=64'h0000000000CCBBAA, out_bytes=3. A following full word 0x01..0x08 is correct with no residue.
4. Backpressure:
   - Complete a word 0x11..0x18 with out_ready=0 -> in_ready=0 and out_data=64'h1817161514131211 stable for 5 cycles.
   - Raise out_ready -> word retires and in_ready=1 next cycle.
5. Reset mid-word:
   - Accept 0xDE, 0xAD, 0xBE, 0xEF, assert reset 1 cycle, then send 0x21..0x28.
   - Required: out_data=64'h2827262524232221 with no stale bytes.
6. LSB_FIRST=0:
   - Beats 0x01..0x08 -> out_data=64'h0102030405060708.
   - Two consecutive words with out_ready=1 -> second word loads on the same edge the first retires; out_valid never drops.
